hazard_detection_unit: RTL and testbench

Pipeline hazard detection and forwarding-select block that produces the `hazard_detected` input consumed by the `controller`. It keeps a small scoreboard of in-flight destination registers in the EXE, MEM and WB stages. It compares the ID-stage source registers against that scoreboard to raise stalls, and generates forwarding selects for the EXE-stage operands. It sits beside the ID/EXE pipeline registers and drives the PC and IF/ID freeze/flush controls.

---
 rtl/hazard_detection_unit_pkg.sv | 11 +
 rtl/hazard_detection_unit_fwd.sv | 47 ++++
 rtl/hazard_detection_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_detection_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_detection_unit_pkg.sv
// Shared constants for the hazard/forwarding block: address width and operand-select encodings.
package hazard_detection_unit_pkg;

    localparam int DEF_REG_ADDR_LEN = 4;
    localparam int FWD_SEL_LEN      = 2;

    localparam logic [FWD_SEL_LEN-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_SEL_LEN-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_SEL_LEN-1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_detection_unit_fwd.sv
// Forwarding select for the two EXE operands; purely combinational, no backpressure.
// A load sitting in MEM has no result yet, so it never forwards and WB is consulted instead.
module forwarding_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN,
    parameter bit FORWARD_EN   = 1'b1
) (
    input  logic                    exe_valid_i,
    input  logic [REG_ADDR_LEN-1:0] exe_src1_i,
    input  logic [REG_ADDR_LEN-1:0] exe_src2_i,
    input  logic                    exe_two_src_i,
    input  logic                    mem_valid_i,
    input  logic [REG_ADDR_LEN-1:0] mem_dest_i,
    input  logic                    mem_wb_en_i,
    input  logic                    mem_mem_r_en_i,
    input  logic                    wb_valid_i,
    input  logic [REG_ADDR_LEN-1:0] wb_dest_i,
    input  logic                    wb_wb_en_i,
    output logic [1:0]              fwd_sel_a_o,
    output logic [1:0]              fwd_sel_b_o
);

    logic mem_fwd_ok;
    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic use_a, use_b;

    assign mem_fwd_ok = mem_valid_i & mem_wb_en_i & ~mem_mem_r_en_i;
    assign mem_hit_a  = mem_fwd_ok & (mem_dest_i == exe_src1_i);
    assign mem_hit_b  = mem_fwd_ok & (mem_dest_i == exe_src2_i);
    assign wb_hit_a   = wb_valid_i & wb_wb_en_i & (wb_dest_i == exe_src1_i);
    assign wb_hit_b   = wb_valid_i & wb_wb_en_i & (wb_dest_i == exe_src2_i);
    assign use_a      = exe_valid_i;
    assign use_b      = exe_valid_i & exe_two_src_i;

    always_comb begin
        fwd_sel_a_o = FWD_RF;
        fwd_sel_b_o = FWD_RF;
        if (FORWARD_EN) begin
            if (use_a && mem_hit_a)     fwd_sel_a_o = FWD_MEM;
            else if (use_a && wb_hit_a) fwd_sel_a_o = FWD_WB;
            if (use_b && mem_hit_b)     fwd_sel_b_o = FWD_MEM;
            else if (use_b && wb_hit_b) fwd_sel_b_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Scoreboard of EXE/MEM/WB destinations driving stall, flush and forwarding selects; outputs are
// combinational (zero latency) from the registered slots and ID inputs; mem_freeze holds every slot.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter bit FORWARD_EN   = 1'b1,
    parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [REG_ADDR_LEN-1:0] id_src1_i,
    input  logic [REG_ADDR_LEN-1:0] id_src2_i,
    input  logic                    id_two_src_i,
    input  logic [REG_ADDR_LEN-1:0] id_dest_i,
    input  logic                    id_wb_en_i,
    input  logic                    id_mem_r_en_i,
    input  logic                    branch_taken_i,
    input  logic                    mem_freeze_i,
    output logic                    hazard_detected_o,
    output logic                    pc_freeze_o,
    output logic                    ifid_freeze_o,
    output logic                    ifid_flush_o,
    output logic [1:0]              fwd_sel_a_o,
    output logic [1:0]              fwd_sel_b_o,
    output logic [15:0]             stall_count_o
);

    logic                    exe_valid_q, exe_valid_d;
    logic [REG_ADDR_LEN-1:0] exe_dest_q, exe_dest_d;
    logic                    exe_wb_en_q, exe_wb_en_d;
    logic                    exe_mem_r_en_q, exe_mem_r_en_d;
    logic [REG_ADDR_LEN-1:0] exe_src1_q, exe_src1_d;
    logic [REG_ADDR_LEN-1:0] exe_src2_q, exe_src2_d;
    logic                    exe_two_src_q, exe_two_src_d;
    logic                    mem_valid_q, mem_valid_d;
    logic [REG_ADDR_LEN-1:0] mem_dest_q, mem_dest_d;
    logic                    mem_wb_en_q, mem_wb_en_d;
    logic                    mem_mem_r_en_q, mem_mem_r_en_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_ADDR_LEN-1:0] wb_dest_q, wb_dest_d;
    logic                    wb_wb_en_q, wb_wb_en_d;
    logic [15:0]             stall_count_q, stall_count_d;

    logic exe_hit, mem_hit, raw_hazard, bubble;

    // src2 only counts when the ID instruction actually reads it.
    assign exe_hit = exe_valid_q & exe_wb_en_q &
                     ((exe_dest_q == id_src1_i) | (id_two_src_i & (exe_dest_q == id_src2_i)));
    assign mem_hit = mem_valid_q & mem_wb_en_q &
                     ((mem_dest_q == id_src1_i) | (id_two_src_i & (mem_dest_q == id_src2_i)));

    assign raw_hazard = FORWARD_EN ? (exe_hit & exe_mem_r_en_q) : (exe_hit | mem_hit);

    // A taken branch makes the ID instruction wrong-path, so it must not stall.
    assign hazard_detected_o = raw_hazard & ~branch_taken_i;
    assign pc_freeze_o       = hazard_detected_o;
    assign ifid_freeze_o     = hazard_detected_o;
    assign ifid_flush_o      = branch_taken_i;
    assign stall_count_o     = stall_count_q;
    assign bubble            = hazard_detected_o | branch_taken_i;

    always_comb begin
        exe_valid_d    = exe_valid_q;
        exe_dest_d     = exe_dest_q;
        exe_wb_en_d    = exe_wb_en_q;
        exe_mem_r_en_d = exe_mem_r_en_q;
        exe_src1_d     = exe_src1_q;
        exe_src2_d     = exe_src2_q;
        exe_two_src_d  = exe_two_src_q;
        mem_valid_d    = mem_valid_q;
        mem_dest_d     = mem_dest_q;
        mem_wb_en_d    = mem_wb_en_q;
        mem_mem_r_en_d = mem_mem_r_en_q;
        wb_valid_d     = wb_valid_q;
        wb_dest_d      = wb_dest_q;
        wb_wb_en_d     = wb_wb_en_q;
        stall_count_d  = stall_count_q;
        if (!mem_freeze_i) begin
            wb_valid_d     = mem_valid_q;
            wb_dest_d      = mem_dest_q;
            wb_wb_en_d     = mem_wb_en_q;
            mem_valid_d    = exe_valid_q;
            mem_dest_d     = exe_dest_q;
            mem_wb_en_d    = exe_wb_en_q;
            mem_mem_r_en_d = exe_mem_r_en_q;
            exe_valid_d    = ~bubble;
            exe_dest_d     = bubble ? '0 : id_dest_i;
            exe_wb_en_d    = ~bubble & id_wb_en_i;
            exe_mem_r_en_d = ~bubble & id_mem_r_en_i;
            exe_src1_d     = bubble ? '0 : id_src1_i;
            exe_src2_d     = bubble ? '0 : id_src2_i;
            exe_two_src_d  = ~bubble & id_two_src_i;
            if (hazard_detected_o && stall_count_q != 16'hFFFF)
                stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exe_valid_q    <= 1'b0;
            exe_dest_q     <= '0;
            exe_wb_en_q    <= 1'b0;
            exe_mem_r_en_q <= 1'b0;
            exe_src1_q     <= '0;
            exe_src2_q     <= '0;
            exe_two_src_q  <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_dest_q     <= '0;
            mem_wb_en_q    <= 1'b0;
            mem_mem_r_en_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_dest_q      <= '0;
            wb_wb_en_q     <= 1'b0;
            stall_count_q  <= 16'd0;
        end else begin
            exe_valid_q    <= exe_valid_d;
            exe_dest_q     <= exe_dest_d;
            exe_wb_en_q    <= exe_wb_en_d;
            exe_mem_r_en_q <= exe_mem_r_en_d;
            exe_src1_q     <= exe_src1_d;
            exe_src2_q     <= exe_src2_d;
            exe_two_src_q  <= exe_two_src_d;
            mem_valid_q    <= mem_valid_d;
            mem_dest_q     <= mem_dest_d;
            mem_wb_en_q    <= mem_wb_en_d;
            mem_mem_r_en_q <= mem_mem_r_en_d;
            wb_valid_q     <= wb_valid_d;
            wb_dest_q      <= wb_dest_d;
            wb_wb_en_q     <= wb_wb_en_d;
            stall_count_q  <= stall_count_d;
        end
    end

    forwarding_unit #(
        .REG_ADDR_LEN (REG_ADDR_LEN),
        .FORWARD_EN   (FORWARD_EN)
    ) u_fwd (
        .exe_valid_i    (exe_valid_q),
        .exe_src1_i     (exe_src1_q),
        .exe_src2_i     (exe_src2_q),
        .exe_two_src_i  (exe_two_src_q),
        .mem_valid_i    (mem_valid_q),
        .mem_dest_i     (mem_dest_q),
        .mem_wb_en_i    (mem_wb_en_q),
        .mem_mem_r_en_i (mem_mem_r_en_q),
        .wb_valid_i     (wb_valid_q),
        .wb_dest_i      (wb_dest_q),
        .wb_wb_en_i     (wb_wb_en_q),
        .fwd_sel_a_o    (fwd_sel_a_o),
        .fwd_sel_b_o    (fwd_sel_b_o)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench: one instance with forwarding, one without, each fed by a controller-style gate.
module tb_hazard_detection_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [3:0]  f_src1, f_src2, f_dest;
    logic        f_two, f_wb_raw, f_mr_raw, f_br, f_frz;
    logic        f_wb, f_mr, f_haz, f_pcf, f_iff, f_ifl;
    logic [1:0]  f_fa, f_fb;
    logic [15:0] f_cnt;

    logic [3:0]  n_src1, n_src2, n_dest;
    logic        n_two, n_wb_raw, n_mr_raw, n_br, n_frz;
    logic        n_wb, n_mr, n_haz, n_pcf, n_iff, n_ifl;
    logic [1:0]  n_fa, n_fb;
    logic [15:0] n_cnt;

    assign f_wb = f_wb_raw & ~f_haz;
    assign f_mr = f_mr_raw & ~f_haz;
    assign n_wb = n_wb_raw & ~n_haz;
    assign n_mr = n_mr_raw & ~n_haz;

    hazard_detection_unit #(.FORWARD_EN(1'b1), .REG_ADDR_LEN(4)) dut_f (
        .clk_i(clk), .rst_ni(rst_n),
        .id_src1_i(f_src1), .id_src2_i(f_src2), .id_two_src_i(f_two), .id_dest_i(f_dest),
        .id_wb_en_i(f_wb), .id_mem_r_en_i(f_mr), .branch_taken_i(f_br), .mem_freeze_i(f_frz),
        .hazard_detected_o(f_haz), .pc_freeze_o(f_pcf), .ifid_freeze_o(f_iff),
        .ifid_flush_o(f_ifl), .fwd_sel_a_o(f_fa), .fwd_sel_b_o(f_fb), .stall_count_o(f_cnt)
    );

    hazard_detection_unit #(.FORWARD_EN(1'b0), .REG_ADDR_LEN(4)) dut_n (
        .clk_i(clk), .rst_ni(rst_n),
        .id_src1_i(n_src1), .id_src2_i(n_src2), .id_two_src_i(n_two), .id_dest_i(n_dest),
        .id_wb_en_i(n_wb), .id_mem_r_en_i(n_mr), .branch_taken_i(n_br), .mem_freeze_i(n_frz),
        .hazard_detected_o(n_haz), .pc_freeze_o(n_pcf), .ifid_freeze_o(n_iff),
        .ifid_flush_o(n_ifl), .fwd_sel_a_o(n_fa), .fwd_sel_b_o(n_fb), .stall_count_o(n_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ins_f(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic [3:0] d, input logic wb, input logic mr);
        f_src1 = s1; f_src2 = s2; f_two = two; f_dest = d; f_wb_raw = wb; f_mr_raw = mr;
    endtask

    task automatic ins_n(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic [3:0] d, input logic wb, input logic mr);
        n_src1 = s1; n_src2 = s2; n_two = two; n_dest = d; n_wb_raw = wb; n_mr_raw = mr;
    endtask

    initial begin
        rst_n = 1'b0;
        ins_f(0, 0, 0, 0, 0, 0); f_br = 0; f_frz = 0;
        ins_n(0, 0, 0, 0, 0, 0); n_br = 0; n_frz = 0;
        #3;
        check_eq("rst_haz_f", f_haz, 0);
        check_eq("rst_fwd_f", {f_fa, f_fb}, 0);
        check_eq("rst_cnt_f", f_cnt, 0);
        check_eq("rst_cnt_n", n_cnt, 0);
        #9 rst_n = 1'b1;
        tick;

        // Load-use with forwarding: LDR R3 ; ADD R4,R3,R1
        ins_f(0, 0, 0, 3, 1, 1); #1;
        check_eq("lu_ldr_nohaz", f_haz, 0);
        tick;
        ins_f(3, 1, 1, 4, 1, 0); #1;
        check_eq("lu_haz", f_haz, 1);
        check_eq("lu_pc_frz", f_pcf, 1);
        check_eq("lu_ifid_frz", f_iff, 1);
        check_eq("lu_no_flush", f_ifl, 0);
        tick; #1;
        check_eq("lu_haz_one_cycle", f_haz, 0);
        tick;
        ins_f(0, 0, 0, 0, 0, 0); #1;
        check_eq("lu_fwd_a_wb", f_fa, 2);
        check_eq("lu_fwd_b_rf", f_fb, 0);
        check_eq("lu_cnt", f_cnt, 1);
        tick;

        // src2 ignored when not read: LDR R3 ; op R6,R5,#imm with src2 field = R3
        ins_f(0, 0, 0, 3, 1, 1); tick;
        ins_f(5, 3, 0, 6, 1, 0); #1;
        check_eq("src2_ignored", f_haz, 0);
        tick;

        // ADD R2 ; SUB R5,R1,R2 -> no stall, operand b from MEM
        ins_f(0, 0, 0, 2, 1, 0); tick;
        ins_f(1, 2, 1, 5, 1, 0); #1;
        check_eq("alu_dep_nohaz", f_haz, 0);
        tick;
        ins_f(0, 0, 0, 0, 0, 0); #1;
        check_eq("alu_fwd_b_mem", f_fb, 1);
        check_eq("alu_fwd_a_rf", f_fa, 0);
        tick;

        // Two writers of R2 in flight: the MEM copy is younger and wins
        ins_f(0, 0, 0, 2, 1, 0); tick;
        ins_f(0, 0, 0, 2, 1, 0); tick;
        ins_f(2, 2, 1, 9, 1, 0); tick;
        ins_f(0, 0, 0, 0, 0, 0); #1;
        check_eq("prio_fwd_a_mem", f_fa, 1);
        check_eq("prio_fwd_b_mem", f_fb, 1);
        tick;

        // Load-use coincident with a taken branch
        ins_f(0, 0, 0, 9, 1, 1); tick;
        ins_f(9, 0, 0, 10, 1, 1); f_br = 1; #1;
        check_eq("br_haz_suppressed", f_haz, 0);
        check_eq("br_flush", f_ifl, 1);
        check_eq("br_pc_frz", f_pcf, 0);
        tick;
        f_br = 0;
        ins_f(10, 0, 0, 1, 1, 0); #1;
        check_eq("br_exe_bubble", f_haz, 0);
        check_eq("br_cnt", f_cnt, 1);
        tick;

        // Load-use held under mem_freeze for 3 cycles: ADD R12 ; LDR R11 ; ADD R13,R12,R11
        ins_f(0, 0, 0, 12, 1, 0); tick;
        ins_f(0, 0, 0, 11, 1, 1); tick;
        ins_f(12, 11, 1, 13, 1, 0); f_frz = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("frz_haz_%0d", i), f_haz, 1);
            check_eq($sformatf("frz_cnt_%0d", i), f_cnt, 1);
            tick;
        end
        f_frz = 0; #1;
        check_eq("frz_rel_haz", f_haz, 1);
        tick; #1;
        check_eq("frz_after_haz", f_haz, 0);
        check_eq("frz_after_cnt", f_cnt, 2);
        tick;
        ins_f(0, 0, 0, 0, 0, 0); #1;
        check_eq("frz_fwd_a_rf", f_fa, 0);
        check_eq("frz_fwd_b_wb", f_fb, 2);
        check_eq("frz_final_cnt", f_cnt, 2);
        tick;

        // No forwarding: ADD R2 ; CMP R2,R6 -> two stall cycles
        ins_n(0, 0, 0, 2, 1, 0); tick;
        ins_n(2, 6, 1, 0, 0, 0); #1;
        check_eq("nf_exe_haz_1", n_haz, 1);
        tick; #1;
        check_eq("nf_exe_haz_2", n_haz, 1);
        tick; #1;
        check_eq("nf_exe_haz_done", n_haz, 0);
        check_eq("nf_exe_cnt", n_cnt, 2);
        check_eq("nf_fwd_rf", {n_fa, n_fb}, 0);
        tick;
        // ADD R7 ; NOP ; ORR R8,R7 -> one stall on MEM, none once it reaches WB
        ins_n(0, 0, 0, 7, 1, 0); tick;
        ins_n(0, 0, 0, 0, 0, 0); tick;
        ins_n(7, 0, 0, 8, 1, 0); #1;
        check_eq("nf_mem_haz", n_haz, 1);
        tick; #1;
        check_eq("nf_wb_nohaz", n_haz, 0);
        check_eq("nf_mem_cnt", n_cnt, 3);
        tick;
        ins_n(0, 0, 0, 0, 0, 0); tick;

        // Build up to 5 stall cycles, then reset in the middle of a pending load-use stall
        for (int k = 0; k < 3; k++) begin
            ins_f(0, 0, 0, 3, 1, 1); tick;
            ins_f(3, 0, 0, 4, 1, 0); tick;
            tick;
        end
        ins_f(0, 0, 0, 3, 1, 1); tick;
        ins_f(3, 0, 0, 4, 1, 0); #1;
        check_eq("pre_rst_haz", f_haz, 1);
        check_eq("pre_rst_cnt", f_cnt, 5);
        rst_n = 1'b0; #1;
        check_eq("mid_rst_haz", f_haz, 0);
        check_eq("mid_rst_frz", {f_pcf, f_iff, f_ifl}, 0);
        check_eq("mid_rst_fwd", {f_fa, f_fb}, 0);
        check_eq("mid_rst_cnt_f", f_cnt, 0);
        check_eq("mid_rst_cnt_n", n_cnt, 0);
        #1 rst_n = 1'b1; #1;
        check_eq("post_rst_nohaz", f_haz, 0);
        tick; #1;
        check_eq("post_rst_cnt", f_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
